// File: rtl/uart_rcv_ctrl.sv
// UART receive controller: synchronizes the serial line, frames one byte
// (start, 8 data bits LSB first, stop), hands the stop bit to an external
// stop-bit checker and loads the byte unless the checker flags a framing error.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to mid start bit; sample at H-1, decide at H (glitch reject)
// DATA  | sampling 8 data bits, one every N clocks
// STOP  | sampling the stop bit into stop_bit
// SBC   | one-cycle sbc_enable strobe to the stop-bit checker
// CHECK | reading the checker's registered framing_error
// LOAD  | transferring the byte to rx_data, updating data_ready/overrun_error
module uart_rcv_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       serial_in,
  input  logic       framing_error,
  input  logic       data_read,
  output logic       sbc_clear,
  output logic       sbc_enable,
  output logic       stop_bit,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       overrun_error
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] HALF    = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    SBC   = 3'd4,
    CHECK = 3'd5,
    LOAD  = 3'd6
  } state_t;

  state_t      state_q;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic        sync1_q;
  logic        sync2_q;
  logic        hist_q;
  logic        samp_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  rx_data_q;
  logic        stop_bit_q;
  logic        data_ready_q;
  logic        overrun_q;
  logic        sbc_clear_q;
  logic        sbc_enable_q;
  logic        start_edge;

  // Free-running increment; every state transition overrides it with zero.
  always_comb begin
    timer_d = timer_q + 16'd1;
  end

  assign start_edge = hist_q & ~sync2_q;

  // Synchronizer, bit timer, frame FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      timer_q      <= 16'd0;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      hist_q       <= 1'b1;
      samp_q       <= 1'b1;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_data_q    <= 8'h00;
      stop_bit_q   <= 1'b1;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      sbc_clear_q  <= 1'b0;
      sbc_enable_q <= 1'b0;
    end else begin
      sync1_q      <= serial_in;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      sbc_clear_q  <= 1'b0;
      sbc_enable_q <= 1'b0;
      timer_q      <= timer_d;

      // An acknowledge outside LOAD clears both flags; LOAD overrides below.
      if (data_read) begin
        data_ready_q <= 1'b0;
        overrun_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          timer_q <= 16'd0;
          if (start_edge) begin
            state_q     <= START;
            sbc_clear_q <= 1'b1;
          end
        end

        START: begin
          if (timer_q == HALF_M1) begin
            samp_q <= sync2_q;
          end
          if (timer_q == HALF) begin
            timer_q <= 16'd0;
            if (!samp_q) begin
              state_q   <= DATA;
              bit_cnt_q <= 3'd0;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        DATA: begin
          if (timer_q == FULL_M1) begin
            shift_q   <= {sync2_q, shift_q[7:1]};
            timer_q   <= 16'd0;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end

        STOP: begin
          if (timer_q == FULL_M1) begin
            stop_bit_q   <= sync2_q;
            timer_q      <= 16'd0;
            state_q      <= SBC;
            sbc_enable_q <= 1'b1;
          end
        end

        SBC: begin
          timer_q <= 16'd0;
          state_q <= CHECK;
        end

        CHECK: begin
          timer_q <= 16'd0;
          state_q <= framing_error ? IDLE : LOAD;
        end

        LOAD: begin
          timer_q      <= 16'd0;
          rx_data_q    <= shift_q;
          data_ready_q <= 1'b1;
          // An acknowledge in the same cycle consumes the old byte, so no overrun.
          overrun_q    <= data_read ? 1'b0 : (overrun_q | data_ready_q);
          state_q      <= IDLE;
        end

        default: begin
          timer_q <= 16'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sbc_clear     = sbc_clear_q;
  assign sbc_enable    = sbc_enable_q;
  assign stop_bit      = stop_bit_q;
  assign rx_data       = rx_data_q;
  assign data_ready    = data_ready_q;
  assign overrun_error = overrun_q;

endmodule

// File: doc/uart_rcv_ctrl.md
UART_RCV_CTRL -- requirements
Module: uart_rcv_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10: clocks per serial bit; even, 4..65534.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port serial_in  input  1  asynchronous UART line; idles high.
REQ-005 SHALL have port framing_error  input  1  registered result from the downstream stop-bit checker.
REQ-006 SHALL have port data_read  input  1  consumer pulse acknowledging rx_data.
REQ-007 SHALL have port sbc_clear  output  1  one-cycle pulse clearing the stop-bit checker at frame start.
REQ-008 SHALL have port sbc_enable  output  1  one-cycle pulse telling the checker to evaluate stop_bit.
REQ-009 SHALL have port stop_bit  output  1  registered sample of the stop-bit period.
REQ-010 SHALL have port rx_data  output  8  last good received byte.
REQ-011 SHALL have port data_ready  output  1  rx_data holds an unread byte.
REQ-012 SHALL have port overrun_error  output  1  a byte was loaded while the previous one was unread.

Function
REQ-013 SHALL pass serial_in through a 2-flop synchronizer, then one history flop; start edge = history 1 and sync output 0.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP, SBC, CHECK, LOAD.
REQ-015 SHALL use a 16-bit bit timer cleared on every state entry; H = CLKS_PER_BIT/2, N = CLKS_PER_BIT.
REQ-016 IDLE: on start edge -> START, asserting sbc_clear in the first START cycle only.
REQ-017 START: at timer==H-1 sample the sync line; 0 -> DATA, 1 -> IDLE (glitch reject, no further action).
REQ-018 DATA: at each timer==N-1, shift the sampled bit into the MSB of an 8-bit shift register (LSB-first wire order) and clear the timer; after the 8th sample -> STOP.
REQ-019 STOP: at timer==N-1, register the sampled line into stop_bit and go -> SBC.
REQ-020 SBC: assert sbc_enable for exactly this one cycle; stop_bit is stable throughout; then -> CHECK.
REQ-021 CHECK: read framing_error (already updated by the checker); 0 -> LOAD, 1 -> IDLE discarding the byte.
REQ-022 LOAD: rx_data <= shift register and data_ready <= 1; overrun_error <= 1 if data_ready==1 and data_ready was not acknowledged this cycle; then -> IDLE.
REQ-023 data_read==1 outside LOAD SHALL clear data_ready and overrun_error on the next edge.
REQ-024 data_read==1 in the LOAD cycle: load wins; data_ready stays 1; overrun_error is not set.
REQ-025 With serial_in falling just before edge 0, data_ready SHALL rise at edge 6+H+9N (101 for N=10).
REQ-026 Start edges arriving in any state other than IDLE SHALL be ignored; a new frame starts only from IDLE.
REQ-027 sbc_clear and sbc_enable SHALL never be asserted in the same cycle.

Reset
REQ-028 Rst==1 at a clock edge SHALL force: state IDLE, timer 0, synchronizer and history flops 1, shift register 0, rx_data 0x00, stop_bit 1, data_ready 0, overrun_error 0, sbc_clear 0, sbc_enable 0.
REQ-029 Rst asserted mid-frame SHALL abort the frame with no partial load; reception resumes on the first start edge after release.

Verification
REQ-030 Frame 0xA5 with good stop bit at N=10 -> sbc_clear pulse at edge 3, sbc_enable pulse at edge 99 with stop_bit=1, rx_data=0xA5 and data_ready=1 from edge 101.
REQ-031 Frame 0x3C with stop bit held 0 -> sbc_enable pulse with stop_bit=0, framing_error=1; rx_data and data_ready unchanged.
REQ-032 3-cycle low glitch on idle line -> returns to IDLE from START; no sbc_enable, data_ready stays 0.
REQ-033 Two frames 0x11 then 0x22 with no data_read -> rx_data=0x22, data_ready=1, overrun_error=1; then data_read pulse -> both flags 0.
REQ-034 data_read pulse coincident with the LOAD cycle of a second frame -> data_ready=1, overrun_error=0.
REQ-035 Rst pulse during bit 4 of a frame -> all outputs at reset values; the next full frame 0x5A loads correctly.
